// File: rtl/greater_checker.sv
// Response monitor for a WIDTH-bit a>b comparator: handshakes each vector, waits SETTLE_CYCLES, checks res, tracks coverage.
// Optional `GREATER_CHK_STOP_ON_ERR_EN ends the run in DONE on the first mismatch.
module greater_checker #(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  localparam int NVEC  = 2 ** (2 * WIDTH);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ARMED, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_cap_p0;
  logic [WIDTH-1:0] b_cap_p0;
  logic [SET_W-1:0] settle_cnt;
  logic [NVEC-1:0]  cov;

  logic [2*WIDTH-1:0] cov_idx;
  logic [NVEC-1:0]    cov_next;
  logic               cov_full;
  logic               mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Coverage update includes the vector being checked this cycle
  always_comb begin
    cov_idx  = {a_cap_p0, b_cap_p0};
    cov_next = cov | (NVEC'(1) << cov_idx);
    cov_full = &cov_next;
    mismatch = (res != (a_cap_p0 > b_cap_p0));
  end

  assign in_ready = (state == ARMED);
  assign busy     = (state == ARMED) || (state == SETTLE) || (state == CHECK);
  assign done     = (state == DONE);
  assign pass     = (state == DONE) && (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_cap_p0    <= '0;
      b_cap_p0    <= '0;
      settle_cnt  <= '0;
      cov         <= '0;
      err_count   <= '0;
      vec_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cov         <= '0;
            err_count   <= '0;
            vec_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
            state       <= ARMED;
          end
        end
        // --- stage p0: vector capture ---
        ARMED: begin
          if (in_valid) begin
            a_cap_p0   <= a;
            b_cap_p0   <= b;
            settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CHECK;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        // --- stage p1: sample res and score ---
        CHECK: begin
          cov       <= cov_next;
          vec_count <= sat_inc(vec_count);
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (err_count == '0) begin
              first_err_a <= a_cap_p0;
              first_err_b <= b_cap_p0;
            end
          end
`ifdef GREATER_CHK_STOP_ON_ERR_EN
          state <= (cov_full || mismatch) ? DONE : ARMED;
`else
          state <= cov_full ? DONE : ARMED;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_greater_checker.sv
// Randomized scoreboard bench for greater_checker: a driver feeds permuted vector sets and a monitor compares each check result.
module tb_greater_checker;
  localparam int WIDTH = 2;
  localparam int S     = 4;
  localparam int CNT_W = 8;
  localparam int NVEC  = 16;
`ifdef GREATER_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] vec_count;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;

  greater_checker #(.WIDTH(WIDTH), .SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .res(res), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count),
    .first_err_a(first_err_a), .first_err_b(first_err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vec;
    int err;
    int fa;
    int fb;
    int dn;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: counts and a coverage set indexed by a*4+b
  int m_vec, m_err, m_fa, m_fb;
  bit m_done;
  bit m_cov[NVEC];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < NVEC; i++) if (!m_cov[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_vec = 0; m_err = 0; m_fa = 0; m_fb = 0; m_done = 1'b0;
    for (int i = 0; i < NVEC; i++) m_cov[i] = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_vec_count"}, int'(vec_count), 0);
    check({tag, "_first_err_a"}, int'(first_err_a), 0);
    check({tag, "_first_err_b"}, int'(first_err_b), 0);
  endtask

  // Monitor: every change of vec_count marks a completed CHECK
  int prev_vec = 0;
  always @(negedge clk) begin
    if (rst_n && int'(vec_count) != prev_vec && vec_count != '0) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_vec", int'(vec_count), prev_vec);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mon_vec_count", int'(vec_count), e.vec);
        check("mon_err_count", int'(err_count), e.err);
        check("mon_first_err_a", int'(first_err_a), e.fa);
        check("mon_first_err_b", int'(first_err_b), e.fb);
        check("mon_done", int'(done), e.dn);
      end
    end
    prev_vec = int'(vec_count);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_clear();
    check("start_busy", int'(busy), 1);
    check("start_in_ready", int'(in_ready), 1);
    check("start_vec_count", int'(vec_count), 0);
    check("start_done", int'(done), 0);
  endtask

  task automatic send(input int va, input int vb, input bit bad, input bit glitch,
                      input bit hold_valid, input bit poke_start);
    bit   rv;
    int   n;
    exp_t e;
    rv = ((va > vb) ? 1'b1 : 1'b0) ^ bad;
    @(negedge clk);
    a = WIDTH'(va); b = WIDTH'(vb); res = rv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("accept_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    m_vec++;
    m_cov[va * 4 + vb] = 1'b1;
    if (bad) begin
      if (m_err == 0) begin m_fa = va; m_fb = vb; end
      m_err++;
    end
    m_done = model_full() || (STOP && bad);
    e.vec = m_vec; e.err = m_err; e.fa = m_fa; e.fb = m_fb; e.dn = int'(m_done);
    sb_q.push_back(e);
    #1;
    if (!hold_valid) in_valid = 1'b0;
    for (n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (in_ready || done) break;
      check("settle_busy", int'(busy), 1);
      res   = (glitch && n < S) ? 1'($urandom) : rv;
      start = (poke_start && n == 2) ? 1'b1 : 1'b0;
      if (n == S) in_valid = 1'b0;
    end
    check("latency", n, S + 1);
    in_valid = 1'b0;
    start    = 1'b0;
    res      = rv;
  endtask

  task automatic run_seq(input int fa, input int fb, input bit dup);
    int order[$];
    int j, t;
    pulse_start();
    for (int i = (dup ? 1 : 0); i < NVEC; i++) order.push_back(i);
    for (int i = order.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    if (dup) begin order.push_front(0); order.push_front(0); end
    foreach (order[k]) begin
      if (m_done) break;
      send(order[k] / 4, order[k] % 4, (order[k] / 4 == fa) && (order[k] % 4 == fb),
           1'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (2) @(negedge clk);
    check("final_done", int'(done), 1);
    check("final_pass", int'(pass), (m_err == 0) ? 1 : 0);
    check("final_err_count", int'(err_count), m_err);
    check("final_vec_count", int'(vec_count), m_vec);
    check("final_first_err_a", int'(first_err_a), m_fa);
    check("final_first_err_b", int'(first_err_b), m_fb);
    check("final_busy", int'(busy), 0);
    check("final_in_ready", int'(in_ready), 0);
    check("final_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; res = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    // Clean exhaustive run with settle glitches, in_valid held and start poked while busy
    run_seq(-1, -1, 1'b0);

    // in_valid while DONE must not be captured
    @(negedge clk); a = 2'd3; b = 2'd0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_valid_vec_count", int'(vec_count), m_vec);
    check("done_valid_done", int'(done), 1);
    in_valid = 1'b0;

    // Asynchronous reset asserted mid-cycle while DONE
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst_hold");
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_clear();

    // Single wrong response at a=3, b=1
    run_seq(3, 1, 1'b0);

    // (0,0) twice followed by the other 15
    run_seq(-1, -1, 1'b1);

    // Reset during SETTLE of the fifth vector
    pulse_start();
    for (int i = 0; i < 4; i++) send(i, 3 - i, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); a = 2'd2; b = 2'd2; res = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2;
    check("midrun_settle_busy", int'(busy), 1);
    check("midrun_vec_count", int'(vec_count), 4);
    rst_n = 1'b0;
    #1 check_all_zero("midrun_rst");
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midrun_idle");

    run_seq(-1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
